ldtu_bsl_track: RTL and testbench

LDTU_BSL_TRACK -- requirements
Module: ldtu_bsl_track

---
 rtl/ldtu_bsl_track.sv | 159 +++++++++++++++
 tb/tb_ldtu_bsl_track.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_bsl_track.sv
// Per-channel baseline subtraction with a 2-stage pipeline and on-demand
// baseline acquisition (average of 2^LOG2_AVG valid samples).
module ldtu_bsl_track #(
  parameter int unsigned NBITS    = 12,
  parameter int unsigned NBSL     = 8,
  parameter int unsigned NCH      = 2,
  parameter int unsigned LOG2_AVG = 4
) (
  input  logic                  DCLK,
  input  logic                  rst_b,
  input  logic [NCH*NBITS-1:0]  data_in,
  input  logic                  data_valid,
  input  logic [NCH-1:0]        bsl_mode,
  input  logic [NCH*NBSL-1:0]   bsl_val,
  input  logic                  acq_start,
  input  logic                  flag_clr,
  output logic [NCH*NBITS-1:0]  data_out,
  output logic                  data_out_valid,
  output logic [NCH*NBSL-1:0]   bsl_acq,
  output logic                  acq_busy,
  output logic                  acq_done,
  output logic [NCH-1:0]        uflow,
  output logic [NCH-1:0]        acq_sat
);

  localparam int unsigned ACC_W = NBITS + LOG2_AVG;
  localparam int unsigned CNT_W = LOG2_AVG + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << LOG2_AVG;
  localparam logic [ACC_W-1:0] BSL_MAX  = ACC_W'((64'd1 << NBSL) - 64'd1);

  typedef enum logic [1:0] {IDLE, ACQ, DONE} state_e;

  state_e                     state_q, state_d;
  logic [NCH*NBITS-1:0]       s1_q, s1_d;
  logic                       v1_q;
  logic [NCH*NBITS-1:0]       dout_q, dout_d;
  logic                       dvalid_q;
  logic [NCH*NBSL-1:0]        bsl_acq_q, bsl_acq_d;
  logic [NCH-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [NCH-1:0]             uflow_q, uflow_d, uflow_set;
  logic [NCH-1:0]             sat_q, sat_d, sat_set;
  logic [NCH-1:0][NBITS-1:0]  base_c, smp_c;

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Effective baseline per channel, zero-extended to the sample width
  always_comb begin
    base_c = '0;
    smp_c  = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      base_c[c] = bsl_mode[c] ? NBITS'(bsl_acq_q[c*NBSL +: NBSL])
                              : NBITS'(bsl_val[c*NBSL +: NBSL]);
      smp_c[c]  = s1_q[c*NBITS +: NBITS];
    end
  end

  always_ff @(posedge DCLK or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acq_start) state_d = ACQ;
      ACQ:     if (data_valid && (cnt_inc == CNT_FULL)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s1_d      = data_valid ? data_in : s1_q;
    dout_d    = dout_q;
    uflow_set = '0;
    sat_set   = '0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    bsl_acq_d = bsl_acq_q;

    if (v1_q) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (smp_c[c] >= base_c[c]) begin
          dout_d[c*NBITS +: NBITS] = smp_c[c] - base_c[c];
        end else begin
          dout_d[c*NBITS +: NBITS] = '0;
          uflow_set[c]             = 1'b1;
        end
      end
    end

    if ((state_q == IDLE) && acq_start) begin
      acc_d = '0;
      cnt_d = '0;
    end else if ((state_q == ACQ) && data_valid) begin
      cnt_d = cnt_inc;
      for (int c = 0; c < int'(NCH); c++) begin
        acc_d[c] = acc_q[c] + ACC_W'(data_in[c*NBITS +: NBITS]);
      end
    end

    // Averages land on the ACQ->DONE edge, so the datapath sees them one edge later
    if ((state_q == ACQ) && (state_d == DONE)) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if ((acc_d[c] >> LOG2_AVG) > BSL_MAX) begin
          bsl_acq_d[c*NBSL +: NBSL] = '1;
          sat_set[c]                = 1'b1;
        end else begin
          bsl_acq_d[c*NBSL +: NBSL] = NBSL'(acc_d[c] >> LOG2_AVG);
        end
      end
    end

    uflow_d = (flag_clr ? '0 : uflow_q) | uflow_set;
    sat_d   = (flag_clr ? '0 : sat_q) | sat_set;
    busy_d  = (state_d == ACQ);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge DCLK or negedge rst_b) begin
    if (!rst_b) begin
      s1_q      <= '0;
      v1_q      <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      bsl_acq_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      uflow_q   <= '0;
      sat_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      v1_q      <= data_valid;
      dout_q    <= dout_d;
      dvalid_q  <= v1_q;
      bsl_acq_q <= bsl_acq_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      uflow_q   <= uflow_d;
      sat_q     <= sat_d;
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = dvalid_q;
  assign bsl_acq        = bsl_acq_q;
  assign acq_busy       = busy_q;
  assign acq_done       = done_q;
  assign uflow          = uflow_q;
  assign acq_sat        = sat_q;

endmodule

// File: tb/tb_ldtu_bsl_track.sv
// Bench for ldtu_bsl_track: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_ldtu_bsl_track;

  localparam int NB = 12;
  localparam int NS = 8;

  logic          DCLK;
  logic          rst_b;
  logic [2*NB-1:0] data_in;
  logic          data_valid;
  logic [1:0]    bsl_mode;
  logic [2*NS-1:0] bsl_val;
  logic          acq_start;
  logic          flag_clr;
  logic [2*NB-1:0] data_out;
  logic          data_out_valid;
  logic [2*NS-1:0] bsl_acq;
  logic          acq_busy;
  logic          acq_done;
  logic [1:0]    uflow;
  logic [1:0]    acq_sat;

  int checks = 0;
  int errors = 0;

  ldtu_bsl_track dut (
    .DCLK(DCLK), .rst_b(rst_b), .data_in(data_in), .data_valid(data_valid),
    .bsl_mode(bsl_mode), .bsl_val(bsl_val), .acq_start(acq_start),
    .flag_clr(flag_clr), .data_out(data_out), .data_out_valid(data_out_valid),
    .bsl_acq(bsl_acq), .acq_busy(acq_busy), .acq_done(acq_done),
    .uflow(uflow), .acq_sat(acq_sat)
  );

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dout(input int c);
    return int'(data_out[c*NB +: NB]);
  endfunction

  function automatic int bacq(input int c);
    return int'(bsl_acq[c*NS +: NS]);
  endfunction

  // Model: pipeline contents, acquisition progress and sticky flags
  int m_s1 [2];
  int m_dout [2];
  int m_bsl [2];
  int m_sum [2];
  int m_n;
  bit m_v1, m_dv;
  bit [1:0] m_uf, m_sat;
  int m_phase;  // 0 idle, 1 acquiring, 2 just finished

  always @(posedge DCLK) begin : model
    int base, avg, smp;
    bit [1:0] uf_ev, sat_ev;
    if (!rst_b) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_dout[c] = 0; m_bsl[c] = 0; m_sum[c] = 0;
      end
      m_n = 0; m_v1 = 0; m_dv = 0; m_uf = 0; m_sat = 0; m_phase = 0;
    end else begin
      uf_ev = 0;
      sat_ev = 0;
      if (m_v1) begin
        for (int c = 0; c < 2; c++) begin
          base = bsl_mode[c] ? m_bsl[c] : int'(bsl_val[c*NS +: NS]);
          if (m_s1[c] >= base) m_dout[c] = m_s1[c] - base;
          else begin m_dout[c] = 0; uf_ev[c] = 1; end
        end
      end
      m_dv = m_v1;
      if (m_phase == 2) m_phase = 0;
      else if (m_phase == 0 && acq_start) begin
        m_phase = 1; m_n = 0; m_sum[0] = 0; m_sum[1] = 0;
      end else if (m_phase == 1 && data_valid) begin
        m_n++;
        for (int c = 0; c < 2; c++) m_sum[c] += int'(data_in[c*NB +: NB]);
        if (m_n == 16) begin
          m_phase = 2;
          for (int c = 0; c < 2; c++) begin
            avg = m_sum[c] / 16;
            if (avg > 255) begin m_bsl[c] = 255; sat_ev[c] = 1; end
            else m_bsl[c] = avg;
          end
        end
      end
      m_uf  = (flag_clr ? 2'b00 : m_uf) | uf_ev;
      m_sat = (flag_clr ? 2'b00 : m_sat) | sat_ev;
      if (data_valid)
        for (int c = 0; c < 2; c++) begin
          smp = int'(data_in[c*NB +: NB]);
          m_s1[c] = smp;
        end
      m_v1 = data_valid;
    end
    #1;
    chk("cyc_dout0", 32'(dout(0)), 32'(m_dout[0]));
    chk("cyc_dout1", 32'(dout(1)), 32'(m_dout[1]));
    chk("cyc_valid", 32'(data_out_valid), 32'(m_dv));
    chk("cyc_bsl0", 32'(bacq(0)), 32'(m_bsl[0]));
    chk("cyc_bsl1", 32'(bacq(1)), 32'(m_bsl[1]));
    chk("cyc_busy", 32'(acq_busy), 32'(m_phase == 1));
    chk("cyc_done", 32'(acq_done), 32'(m_phase == 2));
    chk("cyc_uflow", 32'(uflow), 32'(m_uf));
    chk("cyc_sat", 32'(acq_sat), 32'(m_sat));
  end

  task automatic drive(input logic dv, input int d0, input int d1);
    data_valid = dv;
    data_in    = {12'(d1), 12'(d0)};
    @(negedge DCLK);
  endtask

  int busy_cnt;

  initial begin
    rst_b = 1'b0; data_valid = 1'b0; data_in = '0; bsl_mode = '0;
    bsl_val = '0; acq_start = 1'b0; flag_clr = 1'b0;
    repeat (2) @(negedge DCLK);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_valid", 32'(data_out_valid), 0);
    chk("rst_bsl", 32'(bsl_acq), 0);
    chk("rst_busy", 32'(acq_busy), 0);
    chk("rst_flags", 32'({uflow, acq_sat}), 0);
    rst_b = 1'b1;

    // Fixed baselines 10/20, samples of 100
    bsl_val = {8'd20, 8'd10};
    drive(1, 100, 100);
    chk("lat1_valid", 32'(data_out_valid), 0);
    drive(0, 0, 0);
    chk("fix_ch0", 32'(dout(0)), 90);
    chk("fix_ch1", 32'(dout(1)), 80);
    chk("fix_valid", 32'(data_out_valid), 1);
    chk("fix_uflow", 32'(uflow), 0);
    drive(0, 0, 0);
    chk("hold_valid", 32'(data_out_valid), 0);
    chk("hold_ch0", 32'(dout(0)), 90);

    // Underflow on ch0 is sticky until flag_clr
    bsl_val = {8'd20, 8'd50};
    drive(1, 30, 100);
    drive(0, 0, 0);
    chk("uf_ch0", 32'(dout(0)), 0);
    chk("uf_ch1", 32'(dout(1)), 80);
    chk("uf_flag", 32'(uflow), 1);
    repeat (3) drive(0, 0, 0);
    chk("uf_sticky", 32'(uflow), 1);
    flag_clr = 1'b1;
    drive(0, 0, 0);
    flag_clr = 1'b0;
    chk("uf_cleared", 32'(uflow), 0);

    // Acquisition: 16 valid samples with 4 gaps, a stray acq_start inside
    bsl_val = {8'd20, 8'd10};
    acq_start = 1'b1;
    drive(0, 0, 0);
    acq_start = 1'b0;
    busy_cnt = int'(acq_busy);
    for (int i = 0; i < 20; i++) begin
      acq_start = (i == 6);
      drive((i == 2 || i == 6 || i == 10 || i == 14) ? 1'b0 : 1'b1, 40, 300);
      if (acq_busy) busy_cnt++;
    end
    acq_start = 1'b0;
    chk("acq_done", 32'(acq_done), 1);
    chk("acq_bsl0", 32'(bacq(0)), 40);
    chk("acq_bsl1", 32'(bacq(1)), 255);
    chk("acq_sat", 32'(acq_sat), 2);
    chk("acq_busy_cycles", 32'(busy_cnt), 20);
    drive(0, 0, 0);
    chk("acq_done_pulse", 32'(acq_done), 0);
    chk("acq_idle", 32'(acq_busy), 0);

    // Acquired baselines in use: 300-255 and 100-40
    bsl_mode = 2'b10;
    drive(1, 100, 300);
    drive(0, 0, 0);
    chk("sat_ch1", 32'(dout(1)), 45);
    chk("sat_ch0_fixed", 32'(dout(0)), 90);
    bsl_mode = 2'b11;
    drive(1, 100, 300);
    drive(0, 0, 0);
    chk("acqmode_ch0", 32'(dout(0)), 60);

    // flag_clr coinciding with a fresh underflow: set wins
    flag_clr = 1'b1;
    drive(0, 0, 0);
    flag_clr = 1'b0;
    chk("sat_cleared", 32'(acq_sat), 0);
    bsl_mode = 2'b00;
    bsl_val = {8'd20, 8'd50};
    drive(1, 30, 100);
    flag_clr = 1'b1;
    drive(0, 0, 0);
    flag_clr = 1'b0;
    chk("uf_set_wins", 32'(uflow), 1);

    // Reset in the middle of an acquisition
    bsl_val = {8'd20, 8'd10};
    acq_start = 1'b1;
    drive(0, 0, 0);
    acq_start = 1'b0;
    repeat (7) drive(1, 40, 40);
    chk("mid_busy", 32'(acq_busy), 1);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(acq_busy), 0);
    chk("mid_rst_bsl", 32'(bsl_acq), 0);
    chk("mid_rst_done", 32'(acq_done), 0);
    @(negedge DCLK);
    rst_b = 1'b1;
    acq_start = 1'b1;
    drive(0, 0, 0);
    acq_start = 1'b0;
    for (int i = 0; i < 16; i++) drive(1, (i % 2) ? 70 : 60, (i % 2) ? 18 : 17);
    chk("re_done", 32'(acq_done), 1);
    chk("re_bsl0", 32'(bacq(0)), 65);
    chk("re_bsl1", 32'(bacq(1)), 17);
    chk("model_bsl0", 32'(m_bsl[0]), 65);
    repeat (3) drive(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
